// File: rtl/fp_pkg.sv
// Shared constants for the FP adder front-end: binary32 field layout, internal
// 37-bit operand format, class-flag positions, sub_case codes and skid states.
package fp_pkg;

  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int GUARD_BITS = 4;
  localparam int NUM_W      = 1 + EXP_W + 1 + FRAC_W + GUARD_BITS;

  // Internal format: {sign, exponent, hidden, frac, guard zeros}
  localparam int SIGN_BIT = NUM_W - 1;
  localparam int EXP_MSB  = NUM_W - 2;
  localparam int EXP_LSB  = EXP_MSB - EXP_W + 1;
  localparam int MANT_MSB = EXP_LSB - 1;
  localparam int MANT_LSB = 0;

  localparam int CLS_SUB  = 0;
  localparam int CLS_ZERO = 1;
  localparam int CLS_INF  = 2;
  localparam int CLS_NAN  = 3;

  localparam logic [1:0] SUB_NONE = 2'd0;
  localparam logic [1:0] SUB_A    = 2'd1;
  localparam logic [1:0] SUB_B    = 2'd2;
  localparam logic [1:0] SUB_BOTH = 2'd3;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

endpackage

// File: rtl/fp_unpack_one.sv
// Combinational unpack of one IEEE binary operand into the internal format
// plus class flags. Exponent passes through untouched, even for subnormals.
module fp_unpack_one #(
  parameter int EXP_W      = fp_pkg::EXP_W,
  parameter int FRAC_W     = fp_pkg::FRAC_W,
  parameter int GUARD_BITS = fp_pkg::GUARD_BITS,
  localparam int IN_W      = 1 + EXP_W + FRAC_W,
  localparam int NUM_W     = IN_W + 1 + GUARD_BITS
) (
  input  logic [IN_W-1:0]  op,
  output logic [NUM_W-1:0] num,
  output logic [3:0]       cls,
  output logic             exp_zero
);
  import fp_pkg::*;

  logic              sign;
  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;
  logic              e_ones, f_nz;

  assign sign     = op[IN_W-1];
  assign e        = op[FRAC_W +: EXP_W];
  assign f        = op[FRAC_W-1:0];
  assign exp_zero = (e == '0);
  assign e_ones   = &e;
  assign f_nz     = |f;

  // Hidden bit is simply e != 0; NaN payload rides along in f unchanged.
  assign num = {sign, e, ~exp_zero, f, {GUARD_BITS{1'b0}}};

  always_comb begin
    cls           = '0;
    cls[CLS_SUB]  = exp_zero & f_nz;
    cls[CLS_ZERO] = exp_zero & ~f_nz;
    cls[CLS_INF]  = e_ones & ~f_nz;
    cls[CLS_NAN]  = e_ones & f_nz;
  end

endmodule

// File: rtl/fp_unpack_stage.sv
// Registered FP-adder front-end: unpacks an operand pair and presents it
// through a 2-entry skid buffer so in_ready comes straight from state.
module fp_unpack_stage #(
  parameter int EXP_W      = fp_pkg::EXP_W,
  parameter int FRAC_W     = fp_pkg::FRAC_W,
  parameter int GUARD_BITS = fp_pkg::GUARD_BITS,
  localparam int IN_W      = 1 + EXP_W + FRAC_W,
  localparam int NUM_W     = IN_W + 1 + GUARD_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM_W-1:0] out_num_a,
  output logic [NUM_W-1:0] out_num_b,
  output logic [3:0]       out_cls_a,
  output logic [3:0]       out_cls_b,
  output logic [1:0]       out_sub_case
);
  import fp_pkg::*;

  typedef struct packed {
    logic [NUM_W-1:0] num_a;
    logic [NUM_W-1:0] num_b;
    logic [3:0]       cls_a;
    logic [3:0]       cls_b;
    logic [1:0]       sub_case;
  } pair_t;

  logic [1:0][IN_W-1:0]  ops;
  logic [1:0][NUM_W-1:0] nums;
  logic [1:0][3:0]       clss;
  logic [1:0]            ezero;

  assign ops = {in_b, in_a};

  for (genvar i = 0; i < 2; i++) begin : g_unp
    fp_unpack_one #(
      .EXP_W(EXP_W), .FRAC_W(FRAC_W), .GUARD_BITS(GUARD_BITS)
    ) u_unp (
      .op(ops[i]), .num(nums[i]), .cls(clss[i]), .exp_zero(ezero[i])
    );
  end

  pair_t d, m, s;
  skid_state_t state;

  // Zeros count as exponent-zero here; downstream routing keys on e == 0.
  assign d = '{num_a: nums[0], num_b: nums[1], cls_a: clss[0], cls_b: clss[1],
               sub_case: ezero};

  // in_ready is high in EMPTY/ONE, so in_valid alone implies a transfer there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      m     <= '0;
      s     <= '0;
    end else begin
      case (state)
        EMPTY: if (in_valid) begin
          m     <= d;
          state <= ONE;
        end
        ONE: begin
          if (in_valid && out_ready) m <= d;
          else if (in_valid) begin
            s     <= d;
            state <= TWO;
          end else if (out_ready) state <= EMPTY;
        end
        TWO: if (out_ready) begin
          m     <= s;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid    = (state != EMPTY);
  assign in_ready     = (state != TWO);
  assign out_num_a    = m.num_a;
  assign out_num_b    = m.num_b;
  assign out_cls_a    = m.cls_a;
  assign out_cls_b    = m.cls_b;
  assign out_sub_case = m.sub_case;

endmodule

// File: doc/fp_unpack_stage.md
Name: fp_unpack_stage

Overview:
- Registered front-end of the FP adder: accepts two IEEE-754 binary32 operands and emits them in the 37-bit internal format consumed by the subnormal/normal operand-routing stage directly downstream.
- Internal format per operand: [36] sign, [35:28] biased exponent, [27:0] extended mantissa {hidden, frac[22:0], GUARD_BITS zeros}.
- Also emits per-operand class flags and a subnormal-case code, so downstream stages never re-decode the exponent.
- Valid/ready handshake on both sides, 1-cycle latency, 2-entry skid buffer so in_ready is registered.

Parameters:
- EXP_W, 8, exponent width.
- FRAC_W, 23, stored fraction width.
- GUARD_BITS, 4, zero bits appended below the fraction; internal width = 1+EXP_W+1+FRAC_W+GUARD_BITS = 37 at defaults.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  stage can accept a pair this cycle.
- in_a  in  32  IEEE binary32 operand A.
- in_b  in  32  IEEE binary32 operand B.
- out_valid  out  1  out_* fields hold a valid pair.
- out_ready  in  1  downstream accepts the pair.
- out_num_a  out  37  operand A, internal format.
- out_num_b  out  37  operand B, internal format.
- out_cls_a  out  4  {is_nan, is_inf, is_zero, is_sub} for A.
- out_cls_b  out  4  same for B.
- out_sub_case  out  2  0 none subnormal, 1 A only, 2 B only, 3 both.

Behaviour:
- Reset, asynchronous assert, synchronous release: out_valid=0; in_ready=1; out_num_a/b=0; out_cls_a/b=0; out_sub_case=0; skid buffer empty.
- Unpack, combinational before the register; e = exponent field, f = fraction field.
  - sign copied unchanged.
  - exponent copied unchanged, including 0 for subnormals and zero. No denormal exponent adjustment here.
  - hidden bit = (e != 0).
  - mantissa = {hidden, f, GUARD_BITS'b0}.
- Classification:
  - is_zero = (e==0 && f==0)
  - is_sub = (e==0 && f!=0)
  - is_inf = (e==all-ones && f==0)
  - is_nan = (e==all-ones && f!=0)
  - Exactly one flag, or none for a normal operand, is set.
- out_sub_case bit0 = (A exponent==0); bit1 = (B exponent==0). Zeros therefore count as subnormal-exponent, matching downstream routing on exponent==0.
- Handshake:
  - Transfer on a side occurs when valid && ready are both high at a rising edge.
  - out_* fields are stable while out_valid && !out_ready.
  - in_ready depends only on registered state.
- Storage: main register M (drives outputs) and skid register S. States: EMPTY, ONE (M full), TWO (M and S full).
- Transitions:
  - EMPTY: input transfer -> ONE, M loaded.
  - ONE, in transfer and out transfer -> ONE, M reloaded from input.
  - ONE, in transfer only -> TWO, input goes to S.
  - ONE, out transfer only -> EMPTY.
  - ONE, neither -> ONE.
  - TWO: in_ready=0. Out transfer -> ONE, M<=S. Otherwise hold.
- Outputs per state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
- Latency 1 cycle from input transfer to out_valid when downstream is ready. Sustained throughput is 1 pair/cycle.
- Ordering is strictly FIFO; no pair is ever dropped or duplicated.
- rst_n asserted mid-operation discards M and S immediately; out_valid drops asynchronously.
- NaN payload is preserved in the mantissa. No quieting or canonicalisation here.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W, FRAC_W, GUARD_BITS and derived NUM_W=37.
  - Field index constants SIGN_BIT, EXP_MSB/LSB, MANT_MSB/LSB.
  - Class-flag bit positions.
  - sub_case encodings SUB_NONE/SUB_A/SUB_B/SUB_BOTH.
  - State encoding EMPTY/ONE/TWO.
- One sub-module, fp_unpack_one: pure combinational, binary32 -> {37-bit number, 4-bit class}. Instantiated twice.
- Handshake and skid logic live in the top module.

Test Plan:
- in_a=0x3F800000, in_b=0xC0000000, out_ready=1 -> next cycle: out_num_a=0x07F8000000, out_num_b=0x1808000000, cls both 0, sub_case=0.
- in_a=0x00000001, in_b=0x3F800000 -> out_num_a=0x0000000010, cls_a=0001, sub_case=1. Then in_a=0x00000000, in_b=0x00000000 -> both nums 0, cls 0010, sub_case=3.
- in_a=0x7F800000, in_b=0x7FC00000 -> out_num_a=0x0FF8000000 with cls_a=0100; out_num_b=0x0FFC000000 with cls_b=1000.
- Backpressure: out_ready=0, three pairs offered back-to-back -> two accepted, in_ready=0 after second, outputs hold first pair. Release out_ready -> pairs emerge in order with no gap; third is accepted the cycle in_ready returns to 1.
- Random valid/ready toggling over 10k pairs, checked against a scoreboard -> no loss, duplication or reordering; out_* never change while stalled.
- rst_n pulsed low mid-stall in state TWO -> out_valid=0 and in_ready=1 immediately. After release the first new pair appears with 1-cycle latency and no stale data.
